// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer in front of a shared combinational ALU.
// Grant counters are built only when ALU_ARB_STATS_EN is defined.
module alu_arbiter #(
  parameter int WIDTH = 8,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_y,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  output logic             busy,
  output logic [7:0]       gnt_cnt0,
  output logic [7:0]       gnt_cnt1
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [OPW-1:0]   op_q, op_d;
  logic             rv_q, rv_d;
  logic [WIDTH-1:0] rd_q, rd_d;
  logic             rid_q, rid_d;
  logic             gnt0, gnt1;
  logic             acc;

  // Tie goes to whoever was not granted last.
  always_comb begin
    gnt0 = req0_valid & (~req1_valid | last_q);
    gnt1 = req1_valid & (~req0_valid | ~last_q);
  end

  assign req0_ready = rst_n & (state_q == IDLE) & gnt0;
  assign req1_ready = rst_n & (state_q == IDLE) & gnt1;
  assign acc        = req0_ready | req1_ready;

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    rv_d    = rv_q;
    rd_d    = rd_q;
    rid_d   = rid_q;
    unique case (state_q)
      IDLE: begin
        if (acc) begin
          state_d = ISSUE;
          last_d  = req1_ready;
          rid_d   = req1_ready;
          a_d     = req1_ready ? req1_a  : req0_a;
          b_d     = req1_ready ? req1_b  : req0_b;
          op_d    = req1_ready ? req1_op : req0_op;
        end
      end
      ISSUE: begin
        state_d = RESP;
        rd_d    = alu_y;
        rv_d    = 1'b1;
      end
      RESP: begin
        if (rv_q & rsp_ready) begin
          state_d = IDLE;
          rv_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      rv_q    <= 1'b0;
      rd_q    <= '0;
      rid_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      rv_q    <= rv_d;
      rd_q    <= rd_d;
      rid_q   <= rid_d;
    end
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_op    = op_q;
  assign rsp_valid = rv_q;
  assign rsp_data  = rd_q;
  assign rsp_id    = rid_q;
  assign busy      = (state_q != IDLE);

`ifdef ALU_ARB_STATS_EN
  logic [7:0] c0_q, c0_d;
  logic [7:0] c1_q, c1_d;

  // Saturating grant counters.
  always_comb begin
    c0_d = c0_q;
    c1_d = c1_q;
    if (req0_ready && c0_q != 8'hFF) c0_d = c0_q + 8'd1;
    if (req1_ready && c1_q != 8'hFF) c1_d = c1_q + 8'd1;
  end

  // Counter registers, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c0_q <= '0;
      c1_q <= '0;
    end else begin
      c0_q <= c0_d;
      c1_q <= c1_d;
    end
  end

  assign gnt_cnt0 = c0_q;
  assign gnt_cnt1 = c1_q;
`else
  assign gnt_cnt0 = 8'h00;
  assign gnt_cnt1 = 8'h00;
`endif

endmodule
